// File: rtl/uart_rx.sv
// UART 8N1 receiver: mid-bit sampling of a synchronized rx line.
// Define UART_RX_FRAME_ERR_EN to add the rx_frame_err stop-bit check.
module uart_rx #(
  parameter int DIV_RATE  = 260,
  parameter int DIV_CNT_W = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       rx_busy,
  output logic       rx_end,
`ifdef UART_RX_FRAME_ERR_EN
  output logic       rx_frame_err,
`endif
  output logic [7:0] rx_data
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  localparam logic [DIV_CNT_W-1:0] HALF_M1 =
    DIV_CNT_W'(DIV_RATE / 2 - 1);
  localparam logic [DIV_CNT_W-1:0] FULL_M1 =
    DIV_CNT_W'(DIV_RATE - 1);

  logic                 sync1;
  logic                 rx_s;
  state_t               state;
  logic [DIV_CNT_W-1:0] div_cnt;
  logic [2:0]           bit_cnt;
  logic [7:0]           sh;
  // Blocks re-triggering on a line that stayed low after a frame (break).
  logic                 seen_one;

  // Two-flop synchronizer; resets to mark so no false start edge appears.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= rx;
      rx_s  <= sync1;
    end
  end

  // Frame FSM with registered busy/end/data outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      sh       <= '0;
      seen_one <= 1'b0;
      rx_busy  <= 1'b0;
      rx_end   <= 1'b0;
      rx_data  <= '0;
`ifdef UART_RX_FRAME_ERR_EN
      rx_frame_err <= 1'b0;
`endif
    end else begin
      rx_end <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
      rx_frame_err <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (rx_s) begin
            seen_one <= 1'b1;
          end else if (seen_one) begin
            state   <= START;
            div_cnt <= '0;
            rx_busy <= 1'b1;
          end
        end
        START: begin
          if (div_cnt == HALF_M1) begin
            div_cnt <= '0;
            if (rx_s) begin
              state   <= IDLE;
              rx_busy <= 1'b0;
            end else begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        DATA: begin
          if (div_cnt == FULL_M1) begin
            div_cnt <= '0;
            sh      <= {rx_s, sh[7:1]};
            if (bit_cnt == 3'd7) begin
              state <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        STOP: begin
          if (div_cnt == FULL_M1) begin
            div_cnt  <= '0;
            state    <= IDLE;
            rx_busy  <= 1'b0;
            seen_one <= rx_s;
`ifdef UART_RX_FRAME_ERR_EN
            if (rx_s) begin
              rx_end  <= 1'b1;
              rx_data <= sh;
            end else begin
              rx_frame_err <= 1'b1;
            end
`else
            rx_end  <= 1'b1;
            rx_data <= sh;
`endif
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
